// File: rtl/cdb_arbiter_pkg.sv
// Shared machine definitions for the CDB arbiter slice: FU result / CDB packet types,
// branch-resolution types and per-class requester offsets.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_N       = 2;
  localparam int unsigned NUM_FU_ALU  = 1;
  localparam int unsigned NUM_FU_MULT = 1;
  localparam int unsigned NUM_FU_LD   = 1;
  localparam int unsigned NUM_FU_BR   = 1;
  localparam int unsigned NUM_CDB_REQ = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LD + NUM_FU_BR;

  localparam int unsigned cdb_req_base_alu  = 0;
  localparam int unsigned cdb_req_base_mult = cdb_req_base_alu + NUM_FU_ALU;
  localparam int unsigned cdb_req_base_ld   = cdb_req_base_mult + NUM_FU_MULT;
  localparam int unsigned cdb_req_base_br   = cdb_req_base_ld + NUM_FU_LD;

  localparam int unsigned PREG_W    = 6;
  localparam int unsigned ROB_W     = 5;
  localparam int unsigned BR_MASK_W = 4;
  localparam int unsigned XLEN      = 32;

  typedef logic [BR_MASK_W-1:0] BR_MASK;

  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    CLEAR   = 2'd1,
    SQUASH  = 2'd2
  } BR_TASK;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] p_reg_idx;
    logic [XLEN-1:0]   result;
    BR_MASK            b_mask;
    logic [ROB_W-1:0]  rob_idx;
  } FU_RESULT;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] p_reg_idx;
    logic [XLEN-1:0]   result;
    BR_MASK            b_mask;
    logic [ROB_W-1:0]  rob_idx;
  } CDB_PACKET;

  // Squash kills dependent results; clear drops the resolved branch from the mask.
  function automatic FU_RESULT apply_branch(input FU_RESULT r, input BR_TASK t, input BR_MASK id);
    FU_RESULT o;
    o = r;
    if (t == SQUASH && (r.b_mask & id) != '0) o.valid = 1'b0;
    if (t == CLEAR) o.b_mask = r.b_mask & ~id;
    return o;
  endfunction

  // (a + b) mod m for a, b < m.
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned m);
    int unsigned s;
    s = a + b;
    return (s >= m) ? s - m : s;
  endfunction

endpackage

// File: rtl/cdb_rr_psel.sv
// Round-robin multi-port selector: rotates requests by rr_ptr, picks up to N with psel_gen,
// and maps each port's grant back to a requester index.
module cdb_rr_psel
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N       = 2,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]      req,
  input  logic [PTR_W-1:0]        rr_ptr,
  output logic [N-1:0][PTR_W-1:0] gnt_idx,
  output logic [N-1:0]            gnt_valid
);

  logic [NUM_REQ-1:0]        req_rot;
  logic [N-1:0][NUM_REQ-1:0] gnt_bus_rot;

  always_comb begin
    req_rot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_rot[j] = req[PTR_W'(wrap_add(j, 32'(rr_ptr), NUM_REQ))];
    end
  end

  psel_gen #(
    .WIDTH(NUM_REQ),
    .REQS (N)
  ) u_psel (
    .req    (req_rot),
    .gnt_bus(gnt_bus_rot)
  );

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = '0;
    for (int k = 0; k < N; k++) begin
      gnt_valid[k] = |gnt_bus_rot[k];
      for (int j = 0; j < NUM_REQ; j++) begin
        if (gnt_bus_rot[k][j]) gnt_idx[k] = PTR_W'(wrap_add(j, 32'(rr_ptr), NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/psel_gen.sv
// Multi-grant priority selector: gnt_bus[k] is one-hot on the k-th lowest set request bit.
module psel_gen #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REQS  = 2
) (
  input  logic [WIDTH-1:0]           req,
  output logic [REQS-1:0][WIDTH-1:0] gnt_bus
);

  logic [WIDTH-1:0] remaining;
  logic             found;

  always_comb begin
    remaining = req;
    gnt_bus   = '0;
    found     = 1'b0;
    for (int k = 0; k < REQS; k++) begin
      found = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        if (!found && remaining[j]) begin
          gnt_bus[k][j] = 1'b1;
          remaining[j]  = 1'b0;
          found         = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding register per FU, up to N round-robin grants per cycle onto cdb_out.
// Optional perf counters under `CDB_ARB_PERF_EN.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N       = CDB_N,
  parameter int unsigned NUM_REQ = NUM_CDB_REQ,
  localparam int unsigned PTR_W  = $clog2(NUM_REQ),
  localparam int unsigned CNT_W  = $clog2(NUM_REQ + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  FU_RESULT [NUM_REQ-1:0]      fu_done,
  input  BR_MASK                      rem_b_id,
  input  BR_TASK                      br_task,
  output CDB_PACKET [N-1:0]           cdb_out,
  output logic [NUM_REQ-1:0]          fu_stall,
  output logic [CNT_W-1:0]            num_pending
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]                 perf_grants,
  output logic [31:0]                 perf_stall_cycles
`endif
);

  FU_RESULT [NUM_REQ-1:0]  hold_q, hold_d, hold_br, fu_br;
  logic [NUM_REQ-1:0]      req, granted;
  logic [N-1:0][PTR_W-1:0] gnt_idx;
  logic [N-1:0]            gnt_valid;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        pending_d;

  // Reset masks requests so nothing is broadcast or stalled while it is asserted.
  always_comb begin
    hold_br = '0;
    fu_br   = '0;
    req     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hold_br[i] = apply_branch(hold_q[i], br_task, rem_b_id);
      fu_br[i]   = apply_branch(fu_done[i], br_task, rem_b_id);
      req[i]     = hold_br[i].valid & ~reset;
    end
  end

  cdb_rr_psel #(
    .N      (N),
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_rr_psel (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  // Highest valid port holds the last grant in rotated order, so it sets the next pointer.
  always_comb begin
    cdb_out  = '0;
    granted  = '0;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < N; k++) begin
      if (gnt_valid[k]) begin
        cdb_out[k]          = CDB_PACKET'(hold_br[gnt_idx[k]]);
        granted[gnt_idx[k]] = 1'b1;
        rr_ptr_d            = PTR_W'(wrap_add(32'(gnt_idx[k]), 1, NUM_REQ));
      end
    end
    fu_stall = req & ~granted;
  end

  always_comb begin
    hold_d    = '0;
    pending_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fu_done[i].valid && !fu_stall[i]) begin
        hold_d[i] = fu_br[i];
      end else begin
        hold_d[i] = hold_br[i];
        if (granted[i]) hold_d[i].valid = 1'b0;
      end
      pending_d = pending_d + CNT_W'(hold_d[i].valid);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q      <= '0;
      rr_ptr_q    <= '0;
      num_pending <= '0;
    end else begin
      hold_q      <= hold_d;
      rr_ptr_q    <= rr_ptr_d;
      num_pending <= pending_d;
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic [31:0] n_gnt;
  logic [32:0] grants_sum;

  always_comb begin
    n_gnt = '0;
    for (int k = 0; k < N; k++) n_gnt = n_gnt + 32'(gnt_valid[k]);
    grants_sum = {1'b0, perf_grants} + {1'b0, n_gnt};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grants       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_grants <= grants_sum[32] ? '1 : grants_sum[31:0];
      if (|fu_stall && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter (N=2, four requesters): directed stimulus pushes expected
// broadcasts; a negedge monitor pops and compares every valid CDB port.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  typedef struct {
    int        port;
    CDB_PACKET pkt;
  } exp_t;

  logic                  clock;
  logic                  reset;
  FU_RESULT [3:0]        fu_done;
  BR_MASK                rem_b_id;
  BR_TASK                br_task;
  CDB_PACKET [1:0]       cdb_out;
  logic [3:0]            fu_stall;
  logic [2:0]            num_pending;
`ifdef CDB_ARB_PERF_EN
  logic [31:0]           perf_grants;
  logic [31:0]           perf_stall_cycles;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  cdb_arbiter #(
    .N      (2),
    .NUM_REQ(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .fu_done    (fu_done),
    .rem_b_id   (rem_b_id),
    .br_task    (br_task),
    .cdb_out    (cdb_out),
    .fu_stall   (fu_stall),
    .num_pending(num_pending)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_grants      (perf_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic FU_RESULT mk(input int p, input BR_MASK bm);
    FU_RESULT r;
    r.valid     = 1'b1;
    r.p_reg_idx = 6'(p);
    r.result    = 32'(p) * 32'd3 + 32'h1000;
    r.b_mask    = bm;
    r.rob_idx   = 5'(p);
    return r;
  endfunction

  task automatic push(input int port, input int p, input BR_MASK bm);
    exp_t e;
    e.port = port;
    e.pkt  = CDB_PACKET'(mk(p, bm));
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Monitor: every valid port must match the head of the scoreboard; idle ports must be all-zero.
  initial begin
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        if (cdb_out[k].valid) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL cdb_unexpected: port %0d p_reg %0d with nothing expected", k,
                     cdb_out[k].p_reg_idx);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("cdb_port", 64'(k), 64'(e.port));
            chk("cdb_pkt", 64'(cdb_out[k]), 64'(e.pkt));
          end
        end else begin
          chk("cdb_idle_zero", 64'(cdb_out[k]), 64'd0);
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    fu_done  = '0;
    br_task  = NOTHING;
    rem_b_id = '0;
    tick;
    @(negedge clock);
    chk("rst_stall", 64'(fu_stall), 64'd0);
    chk("rst_pending", 64'(num_pending), 64'd0);
    chk("rst_valid0", 64'(cdb_out[0].valid), 64'd0);
    tick;
    reset = 1'b0;

    // Idle
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("idle_stall", 64'(fu_stall), 64'd0);
      chk("idle_pending", 64'(num_pending), 64'd0);
      chk("idle_valid1", 64'(cdb_out[1].valid), 64'd0);
      tick;
    end

    // Oversubscription from rr_ptr=0
    for (int i = 0; i < 4; i++) fu_done[i] = mk(10 + i, 4'b0000);
    push(0, 10, 4'b0000);
    push(1, 11, 4'b0000);
    push(0, 12, 4'b0000);
    push(1, 13, 4'b0000);
    @(negedge clock);
    chk("os_stall_a", 64'(fu_stall), 64'd0);
    tick;
    fu_done[0] = '0;
    fu_done[1] = '0;
    @(negedge clock);
    chk("os_stall_b", 64'(fu_stall), 64'b1100);
    chk("os_pending_b", 64'(num_pending), 64'd4);
    tick;
    fu_done = '0;
    @(negedge clock);
    chk("os_stall_c", 64'(fu_stall), 64'd0);
    chk("os_pending_c", 64'(num_pending), 64'd2);
    tick;

    // Single result on requester 2
    fu_done[2] = mk(17, 4'b0000);
    push(0, 17, 4'b0000);
    @(negedge clock);
    chk("single_pending0", 64'(num_pending), 64'd0);
    tick;
    fu_done = '0;
    @(negedge clock);
    chk("single_valid", 64'(cdb_out[0].valid), 64'd1);
    chk("single_stall", 64'(fu_stall), 64'd0);
    chk("single_pending1", 64'(num_pending), 64'd1);
    tick;

    // Wrap fairness: rr_ptr=3, requesters 3 and 0 continuously valid
    fu_done[0] = mk(30, 4'b0000);
    fu_done[3] = mk(33, 4'b0000);
    push(0, 33, 4'b0000);
    push(1, 30, 4'b0000);
    @(negedge clock);
    chk("single_drained", 64'(cdb_out[0].valid), 64'd0);
    chk("single_pending2", 64'(num_pending), 64'd0);
    tick;
    fu_done[0] = mk(40, 4'b0000);
    fu_done[3] = mk(43, 4'b0000);
    push(0, 43, 4'b0000);
    push(1, 40, 4'b0000);
    @(negedge clock);
    chk("wrap_stall_a", 64'(fu_stall), 64'd0);
    chk("wrap_pending_a", 64'(num_pending), 64'd2);
    tick;
    fu_done = '0;
    @(negedge clock);
    chk("wrap_stall_b", 64'(fu_stall), 64'd0);
    chk("wrap_pending_b", 64'(num_pending), 64'd2);
    tick;

    // Squash of held result 1
    fu_done[0] = mk(20, 4'b0001);
    fu_done[1] = mk(21, 4'b0100);
    push(0, 20, 4'b0001);
    @(negedge clock);
    chk("sq_pending_a", 64'(num_pending), 64'd0);
    tick;
    fu_done  = '0;
    br_task  = SQUASH;
    rem_b_id = 4'b0100;
    @(negedge clock);
    chk("sq_pending_b", 64'(num_pending), 64'd2);
    chk("sq_stall", 64'(fu_stall), 64'd0);
    chk("sq_port1_idle", 64'(cdb_out[1].valid), 64'd0);
    tick;

    // Clear plus back-to-back on requester 0
    br_task    = NOTHING;
    rem_b_id   = '0;
    fu_done[0] = mk(50, 4'b0011);
    push(0, 50, 4'b0001);
    @(negedge clock);
    chk("sq_pending_c", 64'(num_pending), 64'd0);
    tick;
    br_task    = CLEAR;
    rem_b_id   = 4'b0010;
    fu_done[0] = mk(51, 4'b0010);
    push(0, 51, 4'b0000);
    @(negedge clock);
    chk("clr_stall_a", 64'(fu_stall), 64'd0);
    chk("clr_pending_a", 64'(num_pending), 64'd1);
    tick;
    br_task  = NOTHING;
    rem_b_id = '0;
    fu_done  = '0;
    @(negedge clock);
    chk("clr_stall_b", 64'(fu_stall), 64'd0);
    chk("clr_pending_b", 64'(num_pending), 64'd1);
    tick;

    // Reset mid-operation discards a held result
    fu_done[1] = mk(60, 4'b0000);
    @(negedge clock);
    chk("mr_pending_a", 64'(num_pending), 64'd0);
    tick;
    reset   = 1'b1;
    fu_done = '0;
    @(negedge clock);
    chk("mr_stall", 64'(fu_stall), 64'd0);
    chk("mr_valid", 64'(cdb_out[0].valid), 64'd0);
    chk("mr_pending_b", 64'(num_pending), 64'd1);
    tick;
    reset = 1'b0;
    @(negedge clock);
    chk("mr_pending_c", 64'(num_pending), 64'd0);
    tick;
    tick;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
